// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg -- shared types for the Montgomery modular-exponentiation slice.
//
// Contents:
//   modexp_state_t : exponentiation controller sequence states
//   phase_t        : issue/wait sub-phase of every Montgomery operation
//   limb_vec_t     : limb-array operand type at the default configuration
//   mont_one()     : constant builder for the Montgomery ONE operand
// ---------------------------------------------------------------------------
package mont_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_S       = 16;
  // Upper bound on WIDTH*S for any configuration that uses mont_one().
  localparam int MAX_OP_BITS = 8192;

  typedef logic [DEF_S-1:0][DEF_WIDTH-1:0] limb_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_ONE,
    ST_CONV_BASE,
    ST_SQR,
    ST_MUL,
    ST_FROM,
    ST_DONE
  } modexp_state_t;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  // ONE: limb 0 = 1, every other limb 0. Callers truncate to their width.
  function automatic logic [MAX_OP_BITS-1:0] mont_one();
    return MAX_OP_BITS'(1);
  endfunction

endpackage

// File: rtl/montcios.sv
// ---------------------------------------------------------------------------
// montcios -- iterative CIOS Montgomery multiplier: tout = a*b*R^-1 mod n,
// R = 2^(WIDTH*S). One limb of a is consumed per cycle; the final
// conditional subtraction is folded into the last iteration.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : load a and begin; b, n, n_prime must stay stable until done
//   a, b, n       : S limbs of WIDTH bits (a, b < n, n odd)
//   n_prime       : -n^-1 mod 2^WIDTH
//   tout          : product, valid while done is high and held afterwards
//   done          : one-cycle pulse, S+1 cycles after the start cycle
// N is the width of the limb counter and must satisfy 2^N > S-1.
// ---------------------------------------------------------------------------
module montcios #(
  parameter int WIDTH = 64,
  parameter int S     = 16,
  parameter int N     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [S-1:0][WIDTH-1:0] a,
  input  logic [S-1:0][WIDTH-1:0] b,
  input  logic [S-1:0][WIDTH-1:0] n,
  input  logic [WIDTH-1:0]        n_prime,
  output logic [S-1:0][WIDTH-1:0] tout,
  output logic                    done
);

  localparam int WS  = WIDTH * S;
  localparam int TW2 = WS + 2;          // running sum stays below 2n
  localparam int TW  = WS + WIDTH + 2;  // headroom for t + a_i*b + m*n

  logic [S-1:0][WIDTH-1:0] a_q;
  logic [TW2-1:0]          t_q;
  logic [N-1:0]            cnt_q;
  logic                    run_q;
  logic [S-1:0][WIDTH-1:0] tout_q;
  logic                    done_q;

  logic [TW-1:0]    t1, t2;
  logic [WIDTH-1:0] m;
  logic [TW2-1:0]   t_next;
  logic [WS-1:0]    t_red;

  // One CIOS outer iteration: add a_i*b, pick m so the low limb cancels,
  // add m*n and drop the (now zero) low limb.
  always_comb begin
    t1     = TW'(t_q) + TW'(a_q[0]) * TW'(b);
    m      = t1[WIDTH-1:0] * n_prime;
    t2     = t1 + TW'(m) * TW'(n);
    t_next = TW2'(t2 >> WIDTH);
    t_red  = WS'((t_next >= TW2'(n)) ? t_next - TW2'(n) : t_next);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge value of every other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      t_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      tout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q   <= a;
        t_q   <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        t_q <= t_next;
        a_q <= a_q >> WIDTH;
        if (cnt_q == N'(S - 1)) begin
          run_q  <= 1'b0;
          tout_q <= t_red;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + N'(1);
        end
      end
    end
  end

  assign tout = tout_q;
  assign done = done_q;

endmodule

// File: rtl/mont_modexp.sv
// ---------------------------------------------------------------------------
// mont_modexp -- result = base^exp mod n by left-to-right binary
// square-and-multiply in the Montgomery domain, driving one montcios.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle request, accepted only in IDLE
//   base, exp, n, r2  : S limbs of WIDTH bits (r2 = R^2 mod n)
//   exp_bits          : exponent bits to scan (clamped to WIDTH*S)
//   n_prime           : -n^-1 mod 2^WIDTH
//   result            : base^exp mod n, held until the next accepted start
//   busy              : high from the cycle after acceptance until done
//   done              : one-cycle pulse when result is valid
// ---------------------------------------------------------------------------
module mont_modexp
  import mont_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int S     = 16,
  parameter int N     = 6,
  parameter int EBW   = $clog2(WIDTH*S+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [S-1:0][WIDTH-1:0] base,
  input  logic [S-1:0][WIDTH-1:0] exp,
  input  logic [EBW-1:0]          exp_bits,
  input  logic [S-1:0][WIDTH-1:0] n,
  input  logic [WIDTH-1:0]        n_prime,
  input  logic [S-1:0][WIDTH-1:0] r2,
  output logic [S-1:0][WIDTH-1:0] result,
  output logic                    busy,
  output logic                    done
);

  localparam int WS = WIDTH * S;

  typedef logic [S-1:0][WIDTH-1:0] vec_t;

  localparam vec_t ONE = WS'(mont_one());

  modexp_state_t   state_q;
  phase_t          phase_q;
  vec_t            base_q, n_q, r2_q, acc_q, xm_q, result_q;
  logic [WS-1:0]   exp_q;
  logic [EBW-1:0]  eb_q, k_q;
  logic [WIDTH-1:0] np_q;
  logic            busy_q, done_q;

  vec_t            mont_a, mont_b, mont_tout;
  logic            mont_start, mont_done;
  logic            exp_bit;

  assign exp_bit    = |(exp_q & (WS'(1) << k_q));
  assign mont_start = (phase_q == PH_ISSUE) &&
                      (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Operand select for the single multiplier.
  // NOTE: both outputs get a default before the case, so no latch is
  // inferred for the states that do not issue a multiplication.
  always_comb begin
    mont_a = '0;
    mont_b = '0;
    case (state_q)
      ST_CONV_ONE:  begin mont_a = r2_q;   mont_b = ONE;   end
      ST_CONV_BASE: begin mont_a = base_q; mont_b = r2_q;  end
      ST_SQR:       begin mont_a = acc_q;  mont_b = acc_q; end
      ST_MUL:       begin mont_a = acc_q;  mont_b = xm_q;  end
      ST_FROM:      begin mont_a = acc_q;  mont_b = ONE;   end
      default:      ;
    endcase
  end

  montcios #(
    .WIDTH(WIDTH),
    .S    (S),
    .N    (N)
  ) u_montcios (
    .clk    (clk),
    .rst    (~rst_n),
    .start  (mont_start),
    .a      (mont_a),
    .b      (mont_b),
    .n      (n_q),
    .n_prime(np_q),
    .tout   (mont_tout),
    .done   (mont_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_ISSUE;
      base_q   <= '0;
      exp_q    <= '0;
      eb_q     <= '0;
      k_q      <= '0;
      n_q      <= '0;
      np_q     <= '0;
      r2_q     <= '0;
      acc_q    <= '0;
      xm_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q   <= base;
            exp_q    <= exp;
            eb_q     <= (exp_bits > EBW'(WS)) ? EBW'(WS) : exp_bits;
            n_q      <= n;
            np_q     <= n_prime;
            r2_q     <= r2;
            result_q <= '0;
            busy_q   <= 1'b1;
            phase_q  <= PH_ISSUE;
            state_q  <= ST_CONV_ONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          if (phase_q == PH_ISSUE) begin
            phase_q <= PH_WAIT;
          end else if (mont_done) begin
            phase_q <= PH_ISSUE;
            case (state_q)
              ST_CONV_ONE: begin
                acc_q   <= mont_tout;
                state_q <= ST_CONV_BASE;
              end
              ST_CONV_BASE: begin
                xm_q <= mont_tout;
                if (eb_q == '0) begin
                  state_q <= ST_FROM;
                end else begin
                  k_q     <= eb_q - EBW'(1);
                  state_q <= ST_SQR;
                end
              end
              ST_SQR: begin
                acc_q <= mont_tout;
                if (exp_bit)         state_q <= ST_MUL;
                else if (k_q == '0)  state_q <= ST_FROM;
                else                 k_q     <= k_q - EBW'(1);
              end
              ST_MUL: begin
                acc_q <= mont_tout;
                if (k_q == '0) begin
                  state_q <= ST_FROM;
                end else begin
                  k_q     <= k_q - EBW'(1);
                  state_q <= ST_SQR;
                end
              end
              ST_FROM: begin
                result_q <= mont_tout;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= ST_DONE;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mont_modexp.sv
// ---------------------------------------------------------------------------
// tb_mont_modexp -- self-checking bench for mont_modexp.
// dut_s: WIDTH=16, S=1 (table vectors, corner sequences, random small n).
// dut_b: default WIDTH=64, S=16 (random 1024-bit moduli).
// Reference: plain right-to-left modular exponentiation on wide integers.
// ---------------------------------------------------------------------------
module tb_mont_modexp;
  import mont_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic        start_s = 1'b0;
  logic [15:0] base_s = '0, exp_s = '0, n_s = '0, np_s = '0, r2_s = '0;
  logic [4:0]  eb_s = '0;
  logic [15:0] result_s;
  logic        busy_s, done_s;

  // default-size instance
  logic          start_b = 1'b0;
  logic [1023:0] base_b = '0, exp_b = '0, n_b = '0, r2_b = '0;
  logic [63:0]   np_b = '0;
  logic [10:0]   eb_b = '0;
  logic [1023:0] result_b;
  logic          busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  mont_modexp #(.WIDTH(16), .S(1), .N(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .base(base_s), .exp(exp_s),
    .exp_bits(eb_s), .n(n_s), .n_prime(np_s), .r2(r2_s),
    .result(result_s), .busy(busy_s), .done(done_s)
  );

  mont_modexp dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base(base_b), .exp(exp_b),
    .exp_bits(eb_b), .n(n_b), .n_prime(np_b), .r2(r2_b),
    .result(result_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [1023:0] got,
                       input logic [1023:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%h required 0x%h (low 96 bits)",
               name, got[95:0], want[95:0]);
    end
  endtask

  // base^e mod n over the low eb exponent bits, right-to-left.
  function automatic logic [1023:0] ref_modexp(input logic [1023:0] b,
      input logic [1023:0] e, input logic [1023:0] n, input int eb);
    logic [2047:0] r, x, m;
    r = 2048'(1);
    x = 2048'(b);
    m = 2048'(n);
    for (int i = 0; i < eb; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[1023:0];
  endfunction

  function automatic int ref_ops(input logic [1023:0] e, input int eb);
    int c = 3 + eb;
    for (int i = 0; i < eb; i++) c += int'(e[i]);
    return c;
  endfunction

  function automatic logic [15:0] np16(input logic [15:0] nv);
    logic [15:0] inv = nv;
    for (int i = 0; i < 4; i++) inv = inv * (16'd2 - nv * inv);
    return 16'd0 - inv;
  endfunction

  function automatic logic [63:0] np64(input logic [63:0] nv);
    logic [63:0] inv = nv;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - nv * inv);
    return 64'd0 - inv;
  endfunction

  // One full run on the small instance with protocol checks.
  task automatic run_s(input logic [15:0] b, input logic [15:0] e,
                       input logic [4:0] eb, input logic [15:0] want,
                       input int want_ops, input string tag);
    int  ops = 0;
    bit  seen = 1'b0;
    bit  busy_ok = 1'b1;
    @(negedge clk);
    base_s = b; exp_s = e; eb_s = eb; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check({tag, " result cleared at start"}, 1024'(result_s), 1024'(0));
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (dut_s.mont_start) ops++;
      if (done_s) seen = 1'b1;
      else begin
        if (!busy_s) busy_ok = 1'b0;
        @(negedge clk);
      end
    end
    check({tag, " done seen"}, 1024'(seen), 1024'(1));
    check({tag, " result"}, 1024'(result_s), 1024'(want));
    check({tag, " mont ops"}, 1024'(ops), 1024'(want_ops));
    check({tag, " busy held"}, 1024'(busy_ok), 1024'(1));
    check({tag, " busy low at done"}, 1024'(busy_s), 1024'(0));
    @(negedge clk);
    check({tag, " done one cycle"}, 1024'(done_s), 1024'(0));
    check({tag, " result held"}, 1024'(result_s), 1024'(want));
  endtask

  task automatic run_b(input logic [1023:0] b, input logic [1023:0] e,
                       input int eb, input string tag);
    logic [1023:0] want;
    bit seen = 1'b0;
    want = ref_modexp(b, e, n_b, (eb > 1024) ? 1024 : eb);
    @(negedge clk);
    base_b = b; exp_b = e; eb_b = 11'(eb); start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      if (done_b) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, " done seen"}, 1024'(seen), 1024'(1));
    check({tag, " result"}, result_b, want);
    @(negedge clk);
    check({tag, " done one cycle"}, 1024'(done_b), 1024'(0));
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] exp;
    logic [4:0]  eb;
    logic [15:0] want;
    int          ops;
  } vec_s_t;

  vec_s_t tbl[9];

  initial begin
    int  dones;
    bit  seen, reached, busy_ok;
    logic [15:0] nr, br, er;
    logic [4:0]  ebr;
    logic [63:0] t64;
    logic [2048:0] p, nw;

    // n = 13, n_prime = 45371, r2 = 9
    tbl[0] = '{16'd2,  16'd10,     5'd4,  16'd10, 9};
    tbl[1] = '{16'd4,  16'd13,     5'd4,  16'd4,  10};
    tbl[2] = '{16'd7,  16'hFFFF,   5'd0,  16'd1,  3};
    tbl[3] = '{16'd0,  16'd5,      5'd3,  16'd0,  8};
    tbl[4] = '{16'd3,  16'd3,      5'd2,  16'd1,  7};
    tbl[5] = '{16'd5,  16'd2,      5'd2,  16'd12, 6};
    tbl[6] = '{16'd2,  16'hFFFF,   5'd20, 16'd8,  35};  // exp_bits clamped to 16
    tbl[7] = '{16'd6,  16'hFF0B,   5'd4,  16'd11, 10};  // only low 4 bits scanned
    tbl[8] = '{16'd12, 16'd1,      5'd1,  16'd12, 5};

    // reset state
    repeat (3) @(negedge clk);
    check("reset result_s", 1024'(result_s), 1024'(0));
    check("reset busy_s", 1024'(busy_s), 1024'(0));
    check("reset done_s", 1024'(done_s), 1024'(0));
    check("reset result_b", result_b, 1024'(0));
    check("reset busy_b", 1024'(busy_b), 1024'(0));
    rst_n = 1'b1;

    n_s = 16'd13; np_s = 16'd45371; r2_s = 16'd9;
    for (int i = 0; i < 9; i++)
      run_s(tbl[i].base, tbl[i].exp, tbl[i].eb, tbl[i].want, tbl[i].ops,
            $sformatf("tbl%0d", i));

    // start held high throughout a run, with inputs changing underneath
    @(negedge clk);
    base_s = 16'd2; exp_s = 16'd10; eb_s = 5'd4; start_s = 1'b1;
    dones = 0; seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      base_s = 16'($urandom); exp_s = 16'($urandom);
      if (done_s) begin dones++; seen = 1'b1; start_s = 1'b0; end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_s) dones++;
    end
    check("restart ignored done seen", 1024'(seen), 1024'(1));
    check("restart ignored done count", 1024'(dones), 1024'(1));
    check("restart ignored result", 1024'(result_s), 1024'(10));
    run_s(16'd3, 16'd3, 5'd2, 16'd1, 7, "after restart");

    // reset dropped during SQR
    @(negedge clk);
    base_s = 16'd2; exp_s = 16'd10; eb_s = 5'd4; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (dut_s.state_q == ST_SQR) reached = 1'b1;
      else @(negedge clk);
    end
    check("reset test reached SQR", 1024'(reached), 1024'(1));
    rst_n = 1'b0;
    dones = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done_s) dones++;
    end
    check("mid reset busy", 1024'(busy_s), 1024'(0));
    check("mid reset result", 1024'(result_s), 1024'(0));
    rst_n = 1'b1;
    busy_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_s) dones++;
      if (busy_s) busy_ok = 1'b0;
    end
    check("mid reset no done", 1024'(dones), 1024'(0));
    check("mid reset stays idle", 1024'(busy_ok), 1024'(1));
    run_s(16'd5, 16'd2, 5'd2, 16'd12, 6, "after reset");

    // random small moduli
    for (int i = 0; i < 10; i++) begin
      nr  = 16'($urandom_range(3, 65535)) | 16'd1;
      br  = 16'($urandom_range(0, int'(nr) - 1));
      er  = 16'($urandom);
      ebr = 5'($urandom_range(0, 17));
      t64 = 64'd1 << 32;
      n_s = nr; np_s = np16(nr); r2_s = 16'(t64 % 64'(nr));
      run_s(br, er, ebr,
            16'(ref_modexp(1024'(br), 1024'(er), 1024'(nr),
                           (ebr > 16) ? 16 : int'(ebr))),
            ref_ops(1024'(er), (ebr > 16) ? 16 : int'(ebr)),
            $sformatf("rnd_s%0d", i));
    end

    // default-size instance: random odd 1024-bit moduli
    for (int i = 0; i < 20; i++) begin
      logic [1023:0] br_b, er_b;
      if (i % 5 == 0) begin
        for (int w = 0; w < 32; w++) n_b[w*32 +: 32] = $urandom;
        n_b[1023] = 1'b1;
        n_b[0]    = 1'b1;
        np_b = np64(n_b[63:0]);
        p = '0;
        p[2048] = 1'b1;
        nw = 2049'(n_b);
        p = p % nw;
        r2_b = p[1023:0];
      end
      for (int w = 0; w < 32; w++) begin
        br_b[w*32 +: 32] = $urandom;
        er_b[w*32 +: 32] = $urandom;
      end
      br_b = br_b % n_b;
      run_b(br_b, er_b, $urandom_range(0, 40), $sformatf("rnd_b%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mont_modexp.md
Name: mont_modexp

Overview:
- Modular exponentiation controller: result = base^exp mod n, using left-to-right binary square-and-multiply.
- Sits directly upstream of `montcios` and owns the one instance that performs every multiplication.
- Converts operands into the Montgomery domain, runs the exponent scan, then converts the result back out.
- Top-level consumer of the CIOS multiplier for Paillier encrypt/decrypt exponentiations.

Parameters:
- WIDTH, 64, limb width in bits.
- S, 16, number of limbs; operand width is WIDTH*S.
- N, 6, forwarded unchanged to `montcios`.
- EBW, $clog2(WIDTH*S+1), width of `exp_bits`.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  [WIDTH-1:0] x S  base; must be < n
- exp  in  [WIDTH-1:0] x S  exponent; bit k = exp[k/WIDTH][k%WIDTH]
- exp_bits  in  EBW  number of exponent bits to scan, 0..WIDTH*S, from bit exp_bits-1 down to 0
- n  in  [WIDTH-1:0] x S  odd modulus
- n_prime  in  WIDTH  -n^-1 mod 2^WIDTH
- r2  in  [WIDTH-1:0] x S  R^2 mod n, with R = 2^(WIDTH*S)
- result  out  [WIDTH-1:0] x S  base^exp mod n
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when result is valid

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; result, busy, done = 0; all internal registers cleared.
  - `montcios` rst is driven with ~rst_n, so any in-flight multiplication is aborted.
- start in IDLE: latch base, exp, exp_bits, n, n_prime, r2 into registers; busy=1 next cycle. start in any other state is ignored.
- Each Montgomery op is a two-phase sub-sequence:
  - ISSUE: drive mont_a/mont_b, pulse mont_start for exactly 1 cycle.
  - WAIT: hold operands stable until montcios done=1. montcios done is ignored in the ISSUE cycle.
  - On done, capture Tout into the destination register.
- Sequence (ONE = limb0=1, other limbs 0):
  - CONV_ONE: acc = mont(r2, ONE) = R mod n.
  - CONV_BASE: xm = mont(base, r2).
  - bit index k = exp_bits-1. If exp_bits == 0, go directly to FROM.
  - SQR: acc = mont(acc, acc).
  - MUL: acc = mont(acc, xm). Executed only if exp bit k == 1; else skipped.
  - After SQR(/MUL): if k == 0 go to FROM, else k-- and return to SQR.
  - FROM: result = mont(acc, ONE).
  - DONE: done=1 for 1 cycle, busy=0, return to IDLE.
- Op count = 3 + exp_bits + popcount(exp[exp_bits-1:0]).
  - Cycles = op count × (montcios latency + 1) + 2.
- result is held from DONE until the next accepted start, then cleared to 0 at that start.
- exp_bits > WIDTH*S is clamped to WIDTH*S.
- base >= n, even n, or a wrong n_prime/r2: result undefined, but the FSM still terminates with done.
- Reset asserted mid-operation: immediate return to IDLE, no done pulse. The next start after reset runs normally.
- State encoding: IDLE, CONV_ONE, CONV_BASE, SQR, MUL, FROM, DONE, plus a 1-bit issue/wait phase flag.

Decomposition:
- Package `mont_pkg`:
  - state enum `modexp_state_t`.
  - limb-array typedef `limb_vec_t` (WIDTH x S).
  - constant function building ONE.
- Sub-module: one `montcios` instance, driven by a single mux on (mont_a, mont_b) selected by state.
- No other sub-modules; the exponent bit select is an indexed read of the latched exp.

Test Plan (WIDTH=16, S=1, n=13, n_prime=45371, r2=9):
- base=2, exp=10, exp_bits=4 -> result=10; done pulses once; exactly 9 mont_start pulses counted.
- base=4, exp=13, exp_bits=4 -> result=4; busy high throughout; done 1 cycle wide.
- base=7, exp_bits=0 -> result=1 after 3 mont ops; base=0, exp=5, exp_bits=3 -> result=0.
- start reasserted every cycle while busy (base=2, exp=10) -> ignored; result=10, single done; new start afterwards with base=3, exp=3, exp_bits=2 -> result=1.
- rst_n dropped for 2 cycles during SQR -> result=0, busy=0, no done; then base=5, exp=2, exp_bits=2 -> result=12.
- Default parameters (WIDTH=64, S=16), random odd n with software-computed n_prime/r2, 20 random base/exp -> result matches a bigint model.
